// File: rtl/crc_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// crc_stream_arbiter_pkg
// Shared definitions for the CRC stream arbiter: the engine register-select
// codes, the CRC width code, the arbiter FSM state encodings and helpers that
// turn a width code into the shift that MSB-justifies a value in 32 bits.
// -----------------------------------------------------------------------------
package crc_stream_arbiter_pkg;

    // Engine register selects (write side)
    localparam logic [1:0] RS_CRC  = 2'b00;  // CRC register (init on write)
    localparam logic [1:0] RS_POLY = 2'b01;  // polynomial
    localparam logic [1:0] RS_DATA = 2'b10;  // data byte, fed MSB first
    localparam logic [1:0] RS_REFL = 2'b11;  // data byte, bit-reflected first
    // Engine register selects (read side)
    localparam logic [1:0] RS_STAT = 2'b01;  // bit0 = byte finished
    localparam logic [1:0] RS_CRCR = 2'b10;  // CRC register, bit-reversed

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10
    } width_e;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ARB     = 4'd1;
    localparam logic [3:0] ST_WR_POLY = 4'd2;
    localparam logic [3:0] ST_WR_INIT = 4'd3;
    localparam logic [3:0] ST_WAIT    = 4'd4;
    localparam logic [3:0] ST_WR_DATA = 4'd5;
    localparam logic [3:0] ST_POLL    = 4'd6;
    localparam logic [3:0] ST_RD_RES  = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // Width codes 1x both mean 32 bits.
    function automatic width_e decode_width(input logic [1:0] code);
        if (code[1])      return W32;
        else if (code[0]) return W16;
        else              return W8;
    endfunction

    // Left shift that moves a W-bit LSB-justified value to the top of 32 bits.
    function automatic logic [5:0] shift_of(input width_e w);
        case (w)
            W8:      return 6'd24;
            W16:     return 6'd16;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/crc_stream_arbiter_if.sv
// -----------------------------------------------------------------------------
// crc_stream_arbiter_if
// Client-facing handshakes of the CRC stream arbiter: two byte streams in
// (valid/data/last/ready, channel n on bit n / byte n) and one result stream
// out (valid/data/id/ready).
//   slave  : the arbiter side
//   master : the client / testbench side
// -----------------------------------------------------------------------------
interface crc_stream_arbiter_if;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_ready;

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_data, res_id
    );

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/crc_stream_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The last-grant register only moves when a
// frame completes, so the grant stays stable for the whole frame.
//   clk, reset   : clock, async active-high reset (favours ch0 afterwards)
//   req_i[1:0]   : request per channel
//   done_i       : frame-done strobe
//   done_id_i    : channel whose frame just completed
//   gnt_o        : channel to grant (valid when any request is set)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_id_i,
    output logic       gnt_o
);
    logic last_q;

    // Under contention the channel not served last wins.
    assign gnt_o = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       last_q <= 1'b1;
        else if (done_i) last_q <= done_id_i;
    end
endmodule

// File: rtl/crc_stream_arbiter.sv
// -----------------------------------------------------------------------------
// crc_stream_arbiter
// Shares one 4-register CRC engine between two byte-stream clients, one frame
// at a time. Per frame: program polynomial and init from the winner's config,
// write each byte and poll until the engine finishes it, then read the result,
// apply output reflection / final XOR and present it on the result stream.
//   clk, reset         : clock, async active-high reset
//   strm (slave)       : byte streams in, result stream out
//   cfg_*              : per-channel config, ch n in slice n, sampled in ARB
//   crc_cs/rs/wrl/d    : engine bus, combinational decode of the FSM state
//   crc_q              : engine read data (combinational)
// -----------------------------------------------------------------------------
module crc_stream_arbiter
    import crc_stream_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_stream_arbiter_if.slave  strm,
    input  logic [63:0]          cfg_poly,
    input  logic [63:0]          cfg_init,
    input  logic [63:0]          cfg_xorout,
    input  logic [3:0]           cfg_w,
    input  logic [1:0]           cfg_refin,
    input  logic [1:0]           cfg_refout,
    output logic                 crc_cs,
    output logic [1:0]           crc_rs,
    output logic [3:0]           crc_wrl,
    output logic [31:0]          crc_d,
    input  logic [31:0]          crc_q
);
    logic [3:0]      state_q, state_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic            res_valid_q, res_valid_d;
    logic            res_id_q, res_id_d;
    logic [31:0]     res_data_q, res_data_d;
    // Frame config, held from ARB until the next ARB
    logic [31:0]     poly_q, init_q, xorout_q;
    logic [5:0]      sh_q;
    logic            refin_q, refout_q;

    logic [NREQ-1:0] req;
    logic            gnt;
    logic            frame_done;
    logic [31:0]     wmask;
    logic [31:0]     res_raw;
    logic [1:0]      s_ready_c;

    assign req        = strm.s_valid;
    assign frame_done = (state_q == ST_DONE) && strm.res_ready;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .done_i    (frame_done),
        .done_id_i (id_q),
        .gnt_o     (gnt)
    );

    // The engine keeps the CRC MSB-justified; the reversed read puts it at
    // the bottom, the plain read needs shifting down.
    assign wmask   = 32'hFFFF_FFFF >> sh_q;
    assign res_raw = refout_q ? (crc_q & wmask) : (crc_q >> sh_q);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE:    if (|strm.s_valid) state_d = ST_ARB;
            ST_ARB: begin
                id_d    = gnt;
                state_d = ST_WR_POLY;
            end
            ST_WR_POLY: state_d = ST_WR_INIT;
            ST_WR_INIT: state_d = ST_WAIT;
            ST_WAIT:    if (strm.s_valid[id_q]) state_d = ST_WR_DATA;
            ST_WR_DATA: begin
                last_d  = strm.s_last[id_q];
                state_d = ST_POLL;
            end
            ST_POLL:    if (crc_q[0]) state_d = last_q ? ST_RD_RES : ST_WAIT;
            ST_RD_RES: begin
                res_data_d  = res_raw ^ (xorout_q & wmask);
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (strm.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        crc_cs    = 1'b0;
        crc_rs    = RS_CRC;
        crc_wrl   = 4'b0000;
        crc_d     = 32'h0;
        s_ready_c = 2'b00;
        case (state_q)
            ST_WR_POLY: begin
                crc_cs  = 1'b1;
                crc_rs  = RS_POLY;
                crc_wrl = 4'b1111;
                crc_d   = poly_q << sh_q;
            end
            ST_WR_INIT: begin
                crc_cs  = 1'b1;
                crc_rs  = RS_CRC;
                crc_wrl = 4'b1111;
                crc_d   = init_q << sh_q;
            end
            ST_WR_DATA: begin
                crc_cs        = 1'b1;
                crc_rs        = refin_q ? RS_REFL : RS_DATA;
                crc_wrl       = 4'b0001;
                crc_d         = {24'h0, strm.s_data[{id_q, 3'b000} +: 8]};
                s_ready_c[id_q] = 1'b1;
            end
            ST_POLL: begin
                crc_cs = 1'b1;
                crc_rs = RS_STAT;
            end
            ST_RD_RES: begin
                crc_cs = 1'b1;
                crc_rs = refout_q ? RS_CRCR : RS_CRC;
            end
            default: ;
        endcase
    end

    assign strm.s_ready   = s_ready_c;
    assign strm.res_valid = res_valid_q;
    assign strm.res_data  = res_data_q;
    assign strm.res_id    = res_id_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            last_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    // Config capture for the granted channel; mid-frame changes never reach it.
    always_ff @(posedge clk) begin
        if (state_q == ST_ARB) begin
            poly_q   <= cfg_poly[{gnt, 5'b00000} +: 32];
            init_q   <= cfg_init[{gnt, 5'b00000} +: 32];
            xorout_q <= cfg_xorout[{gnt, 5'b00000} +: 32];
            sh_q     <= shift_of(decode_width(cfg_w[{gnt, 1'b0} +: 2]));
            refin_q  <= cfg_refin[gnt];
            refout_q <= cfg_refout[gnt];
        end
    end
endmodule

// File: tb/tb_crc_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc_stream_arbiter
// Directed bench for crc_stream_arbiter with a bit-serial model of the CRC
// engine (8 shift cycles per byte, status bit0 set once the byte is done).
// -----------------------------------------------------------------------------
module tb_crc_stream_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1, l0, l1, rdy;
    logic [7:0]  d0, d1;
    logic [63:0] cfg_poly, cfg_init, cfg_xorout;
    logic [3:0]  cfg_w;
    logic [1:0]  cfg_refin, cfg_refout;
    logic        crc_cs;
    logic [1:0]  crc_rs;
    logic [3:0]  crc_wrl;
    logic [31:0] crc_d, crc_q;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                              8'h36, 8'h37, 8'h38, 8'h39};

    crc_stream_arbiter_if sif ();
    assign sif.s_valid   = {v1, v0};
    assign sif.s_data    = {d1, d0};
    assign sif.s_last    = {l1, l0};
    assign sif.res_ready = rdy;

    crc_stream_arbiter #(.NREQ(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .strm       (sif),
        .cfg_poly   (cfg_poly),
        .cfg_init   (cfg_init),
        .cfg_xorout (cfg_xorout),
        .cfg_w      (cfg_w),
        .cfg_refin  (cfg_refin),
        .cfg_refout (cfg_refout),
        .crc_cs     (crc_cs),
        .crc_rs     (crc_rs),
        .crc_wrl    (crc_wrl),
        .crc_d      (crc_d),
        .crc_q      (crc_q)
    );

    // ---------------- CRC engine model ----------------
    logic [31:0] e_crc, e_poly;
    logic [7:0]  e_sh;
    int          e_cnt;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        for (int i = 0; i < 8; i++) rev8[i] = x[7-i];
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        for (int i = 0; i < 32; i++) rev32[i] = x[31-i];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_crc <= 32'h0; e_poly <= 32'h0; e_sh <= 8'h0; e_cnt <= 0;
        end else if (crc_cs && crc_wrl != 4'b0000) begin
            case (crc_rs)
                2'b00: e_crc  <= crc_d;
                2'b01: e_poly <= crc_d;
                2'b10: begin e_sh <= crc_d[7:0];       e_cnt <= 8; end
                default: begin e_sh <= rev8(crc_d[7:0]); e_cnt <= 8; end
            endcase
        end else if (e_cnt != 0) begin
            e_crc <= {e_crc[30:0], 1'b0} ^ ((e_crc[31] ^ e_sh[7]) ? e_poly : 32'h0);
            e_sh  <= {e_sh[6:0], 1'b0};
            e_cnt <= e_cnt - 1;
        end
    end

    always_comb begin
        crc_q = 32'h0;
        if (crc_cs) begin
            case (crc_rs)
                2'b00:   crc_q = e_crc;
                2'b01:   crc_q = {31'h0, e_cnt == 0};
                2'b10:   crc_q = rev32(e_crc);
                default: crc_q = 32'h0;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // s_ready must never be set on both channels at once.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert ($onehot0(sif.s_ready)) else begin
                errors++;
                $error("FAIL s_ready_onehot observed=%b expected=onehot0", sif.s_ready);
            end
        end
    end

    task automatic set_cfg(input int ch, input logic [31:0] poly, input logic [31:0] init,
                           input logic [31:0] xo, input logic [1:0] w,
                           input logic ri, input logic ro);
        cfg_poly[32*ch +: 32]   = poly;
        cfg_init[32*ch +: 32]   = init;
        cfg_xorout[32*ch +: 32] = xo;
        cfg_w[2*ch +: 2]        = w;
        cfg_refin[ch]           = ri;
        cfg_refout[ch]          = ro;
    endtask

    // Send n bytes of msg (cyclic) on channel ch, frames of flen bytes.
    task automatic feed(input int ch, input int n, input int flen);
        for (int i = 0; i < n; i++) begin
            int t;
            if (ch == 0) begin v0 = 1'b1; d0 = msg[i % 9]; l0 = ((i % flen) == flen - 1); end
            else         begin v1 = 1'b1; d1 = msg[i % 9]; l1 = ((i % flen) == flen - 1); end
            t = 0;
            do begin @(negedge clk); t++; end while (!sif.s_ready[ch] && t < 400);
            if (!sif.s_ready[ch]) begin
                check($sformatf("feed_ch%0d_byte%0d_timeout", ch, i), {31'h0, sif.s_ready[ch]}, 32'h1);
                i = n;
            end
            @(posedge clk); #1;
        end
        if (ch == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic exp_id,
                              input logic [31:0] exp_data, input bit chk_data);
        int t = 0;
        while (!sif.res_valid && t < 2000) begin @(negedge clk); t++; end
        check({tag, "_valid"}, {31'h0, sif.res_valid}, 32'h1);
        check({tag, "_id"}, {31'h0, sif.res_id}, {31'h0, exp_id});
        if (chk_data) check({tag, "_data"}, sif.res_data, exp_data);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs"},  {31'h0, crc_cs}, 32'h0);
        check({tag, "_rs"},  {30'h0, crc_rs}, 32'h0);
        check({tag, "_wrl"}, {28'h0, crc_wrl}, 32'h0);
        check({tag, "_d"},   crc_d, 32'h0);
        check({tag, "_rdy"}, {30'h0, sif.s_ready}, 32'h0);
        check({tag, "_rv"},  {31'h0, sif.res_valid}, 32'h0);
        check({tag, "_rd"},  sif.res_data, 32'h0);
        check({tag, "_rid"}, {31'h0, sif.res_id}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0; rdy = 0;
        cfg_poly = '0; cfg_init = '0; cfg_xorout = '0; cfg_w = '0;
        cfg_refin = '0; cfg_refout = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // CRC-32 on ch0
        set_cfg(0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1, 1'b1);
        feed(0, 9, 9);
        get_result("crc32", 1'b0, 32'hCBF43926, 1'b1);

        // CRC-16/CCITT-FALSE on ch1
        set_cfg(1, 32'h00001021, 32'h0000FFFF, 32'h0, 2'b01, 1'b0, 1'b0);
        feed(1, 9, 9);
        get_result("crc16", 1'b1, 32'h000029B1, 1'b1);

        // CRC-8, single byte, latency; stray res_ready while idle is ignored
        set_cfg(0, 32'h07, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check("stray_ready_rv", {31'h0, sif.res_valid}, 32'h0);
        v0 = 1'b1; d0 = 8'h31; l0 = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (sif.res_valid) break;
        end
        check("crc8_latency", n, 32'd16);
        check("crc8_data", sif.res_data, 32'h00000097);
        check("crc8_id", {31'h0, sif.res_id}, 32'h0);
        v0 = 1'b0;

        // Result held while res_ready low; pending ch1 gets no s_ready
        v1 = 1'b1; d1 = 8'h31; l1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_rv", {31'h0, sif.res_valid}, 32'h1);
            check("hold_rd", sif.res_data, 32'h00000097);
            check("hold_rdy", {30'h0, sif.s_ready}, 32'h0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check("release_rv", {31'h0, sif.res_valid}, 32'h0);
        n = 0;
        while (!sif.s_ready[1] && n < 50) begin @(negedge clk); n++; end
        check("next_frame_start", {31'h0, sif.s_ready[1]}, 32'h1);
        @(posedge clk); #1;
        v1 = 1'b0;
        get_result("next_frame", 1'b1, 32'h0, 1'b0);

        // Both channels contending with 2-byte frames: grants 0,1,0,1
        set_cfg(1, 32'h00001021, 32'h0000FFFF, 32'h0, 2'b01, 1'b0, 1'b0);
        fork
            feed(0, 4, 2);
            feed(1, 4, 2);
            begin
                get_result("rr0", 1'b0, 32'h00000072, 1'b1);
                get_result("rr1", 1'b1, 32'h0, 1'b0);
                get_result("rr2", 1'b0, 32'h0, 1'b0);
                get_result("rr3", 1'b1, 32'h0, 1'b0);
            end
        join

        // Reset while polling the 5th byte, then rerun CRC-32
        set_cfg(0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1, 1'b1);
        feed(0, 5, 9);
        @(negedge clk);
        check("mid_poll_cs", {31'h0, crc_cs}, 32'h1);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        feed(0, 9, 9);
        get_result("crc32_again", 1'b0, 32'hCBF43926, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
